mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access stage of the 6-stage pipeline. Sits between ex_mem and mem_wb.
- Non-memory instructions pass straight through; mem_wb registers the outputs.
- Loads and stores are executed as a req/ack transaction on the data bus. The block holds stallreq high until the transaction completes or times out.
- Handles big-endian byte-lane selection, load sign/zero extension and misalignment detection.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles bus_req stays asserted without bus_ack before the access is aborted (min 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- stall  in  6  pipeline stall vector from ctrl; bit 4 = this stage
- mem_wd_i  in  5  destination register address
- mem_wreg_i  in  1  register write enable
- mem_wdata_i  in  32  ALU result (non-load write data)
- mem_hi_i  in  32  HI value
- mem_lo_i  in  32  LO value
- mem_whilo_i  in  1  HI/LO write enable
- mem_aluop_i  in  8  operation code
- mem_addr_i  in  32  effective address
- mem_reg2_i  in  32  store data
- mem_wd  out  5  to mem_wb
- mem_wreg  out  1  to mem_wb
- mem_wdata  out  32  to mem_wb
- mem_hi  out  32  to mem_wb
- mem_lo  out  32  to mem_wb
- mem_whilo  out  1  to mem_wb
- bus_req  out  1  access request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address; {mem_addr_i[31:2],2'b00}
- bus_sel  out  4  byte-lane enables
- bus_wdata  out  32  store data, replicated to all lanes
- bus_ack  in  1  access complete (read data valid same cycle)
- bus_rdata  in  32  read data
- stallreq  out  1  stall request to ctrl
- mem_err  out  1  misalign or timeout flag

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, capture reg=0. All outputs 0 (wd=0, wreg/whilo disabled, bus_req=0, stallreq=0, mem_err=0).
- Ops (aluop):
  - LB=0xE0, LBU=0xE4, LH=0xE1, LHU=0xE5, LW=0xE3
  - SB=0xE8, SH=0xE9, SW=0xEB
  - any other value = non-memory op
- Non-memory op: all mem_* outputs equal their _i inputs combinationally. bus_req=0, stallreq=0, mem_err=0.
- Byte lanes, big-endian: addr[1:0]=00 selects bits [31:24] (sel 1000); 01 -> 0100; 10 -> 0010; 11 -> 0001.
  - Half-word: addr[1]=0 -> sel 1100; addr[1]=1 -> sel 0011.
  - Word: sel 1111.
- Misaligned access: half-word with addr[0]=1, or word with addr[1:0]!=00.
  - No bus transaction; stallreq=0.
  - mem_wreg=0, mem_err=1 for that cycle; other outputs pass through.
- FSM:
  - IDLE: an aligned memory op drives bus_req=1, bus_we (1 for stores), sel/addr/wdata, and stallreq=1, all combinationally.
    - bus_ack=1 at the edge -> capture bus_rdata, go DONE.
    - otherwise -> go WAIT, counter=1.
  - WAIT: bus_req=1, stallreq=1.
    - bus_ack -> capture, go DONE.
    - counter==TIMEOUT_CYCLES -> go DONE with err=1.
    - otherwise counter+1.
  - DONE: bus_req=0, stallreq=0.
    - Outputs carry the _i values except mem_wdata = extended captured data for loads.
    - On err: mem_wreg=0, mem_err=1.
    - Stays in DONE while stall[4]=1; goes to IDLE when stall[4]=0, clearing counter and err.
- Load extension: the selected byte or half is placed in bits [7:0]/[15:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Inputs are held stable by ctrl while stallreq=1. The block does not re-latch the address or data.
- bus_ack outside IDLE-with-memory-op/WAIT is ignored.
- rst asserted mid-transaction: immediate return to IDLE. bus_req drops asynchronously.
- Minimum load/store stall = 1 cycle (ack in the first cycle).

Test Plan:
- Non-memory op: ADD result 0x00000005 to $3 -> same cycle mem_wdata=0x5, mem_wreg=1, stallreq=0, bus_req=0.
- LB, addr 0x103, rdata 0x123456F0, ack in cycle 1 -> bus_sel=0001, stallreq high for 1 cycle. Next cycle mem_wdata=0xFFFFFFF0, wreg=1. Same stimulus with LBU -> 0x000000F0.
- LH, addr 0x102, ack after 3 wait cycles -> stallreq high for 4 cycles, sel=0011, addr=0x100. DONE: mem_wdata=0x000056F0 with rdata 0x123456F0.
- SW, addr 0x200, data 0xDEADBEEF -> bus_we=1, sel=1111, bus_wdata=0xDEADBEEF until ack, then stallreq=0, mem_wreg=0.
- LW, addr 0x201 -> no bus_req, mem_err=1, mem_wreg=0, stallreq=0. LW with bus_ack never asserted, TIMEOUT_CYCLES=4 -> bus_req high 5 cycles, then DONE with mem_err=1, mem_wreg=0.
- rst pulled low during WAIT -> bus_req and stallreq go 0 immediately. After release, the block is IDLE and the next load completes normally.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: data-bus request/acknowledge channel between the memory stage
// and the data memory.
interface mem_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_ack, bus_rdata
    );
    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access.sv
// mem_access: memory stage; runs loads/stores as bus req/ack transactions with
// big-endian lane select, load extension, misalign and timeout detection.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [4:0]   mem_wd_i,
    input  logic         mem_wreg_i,
    input  logic [31:0]  mem_wdata_i,
    input  logic [31:0]  mem_hi_i,
    input  logic [31:0]  mem_lo_i,
    input  logic         mem_whilo_i,
    input  logic [7:0]   mem_aluop_i,
    input  logic [31:0]  mem_addr_i,
    input  logic [31:0]  mem_reg2_i,
    output logic [4:0]   mem_wd,
    output logic         mem_wreg,
    output logic [31:0]  mem_wdata,
    output logic [31:0]  mem_hi,
    output logic [31:0]  mem_lo,
    output logic         mem_whilo,
    mem_access_if.master bus,
    output logic         stallreq,
    output logic         mem_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] cap_q, cap_d;
    logic err_q, err_d;
    logic is_ld, is_st, is_h, is_w, sgn, misal, idle, done, req;
    logic [31:0] byte_sh, half_sh, ext;
    logic unused;

    assign is_ld = mem_aluop_i inside {8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5};
    assign is_st = mem_aluop_i inside {8'hE8, 8'hE9, 8'hEB};
    assign is_h  = mem_aluop_i inside {8'hE1, 8'hE5, 8'hE9};
    assign is_w  = mem_aluop_i inside {8'hE3, 8'hEB};
    assign sgn   = !mem_aluop_i[2];
    assign misal = (is_h && mem_addr_i[0]) || (is_w && mem_addr_i[1:0] != 2'b00);
    assign idle  = state_q == IDLE;
    assign done  = state_q == DONE;
    assign req   = rst && ((idle && (is_ld || is_st) && !misal) || state_q == WAIT);

    // address byte 0 is the most significant lane
    assign byte_sh = cap_q >> {~mem_addr_i[1:0], 3'b000};
    assign half_sh = cap_q >> {~mem_addr_i[1], 4'b0000};
    assign ext = is_w ? cap_q
               : is_h ? {{16{sgn && half_sh[15]}}, half_sh[15:0]}
               : {{24{sgn && byte_sh[7]}}, byte_sh[7:0]};
    assign unused = ^{stall[5], stall[3:0], byte_sh[31:8], half_sh[31:16]};

    assign bus.bus_req   = req;
    assign bus.bus_we    = req && is_st;
    assign bus.bus_addr  = req ? {mem_addr_i[31:2], 2'b00} : '0;
    assign bus.bus_sel   = !req ? 4'h0 : is_w ? 4'hF : is_h ? (mem_addr_i[1] ? 4'h3 : 4'hC)
                         : 4'b1000 >> mem_addr_i[1:0];
    assign bus.bus_wdata = !req ? '0 : is_w ? mem_reg2_i : is_h ? {2{mem_reg2_i[15:0]}}
                         : {4{mem_reg2_i[7:0]}};
    assign stallreq  = req;
    assign mem_err   = rst && ((idle && misal) || (done && err_q));
    assign mem_wd    = rst ? mem_wd_i : '0;
    assign mem_wreg  = rst && mem_wreg_i && !mem_err;
    assign mem_wdata = !rst ? '0 : (done && is_ld) ? ext : mem_wdata_i;
    assign mem_hi    = rst ? mem_hi_i : '0;
    assign mem_lo    = rst ? mem_lo_i : '0;
    assign mem_whilo = rst && mem_whilo_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        err_d   = err_q;
        if (req && bus.bus_ack) begin
            state_d = DONE;
            cap_d   = bus.bus_rdata;
        end else if (idle && req) begin
            state_d = WAIT;
            cnt_d   = CW'(1);
        end else if (state_q == WAIT) begin
            state_d = cnt_q == CW'(TIMEOUT_CYCLES) ? DONE : WAIT;
            err_d   = cnt_q == CW'(TIMEOUT_CYCLES);
            cnt_d   = cnt_q == CW'(TIMEOUT_CYCLES) ? cnt_q : cnt_q + 1'b1;
        end else if (done && !stall[4]) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: vector table, hand-written reset/pass-through sequences and
// randomized transactions checked against an arithmetic model of mem_access.
module tb_mem_access;
    localparam int T = 4;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, r2, rd;
        int          ack_at, hold, kind;
        logic [3:0]  sel;
        logic [31:0] ld, bw;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic [4:0]  mem_wd_i = '0;
    logic        mem_wreg_i = 1'b0;
    logic [31:0] mem_wdata_i = '0, mem_hi_i = '0, mem_lo_i = '0;
    logic        mem_whilo_i = 1'b0;
    logic [7:0]  mem_aluop_i = '0;
    logic [31:0] mem_addr_i = '0, mem_reg2_i = '0;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo, stallreq, mem_err;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    int checks = 0;
    int errors = 0;
    vec_t tbl[19];
    vec_t v;
    logic [7:0] ops[8] = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB};

    mem_access_if bus_if();

    mem_access #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
        .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i), .mem_whilo_i(mem_whilo_i),
        .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .bus(bus_if.master), .stallreq(stallreq), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        chk(n, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic chk_pass(input string n);
        chk({n, ".wd"}, {27'b0, mem_wd}, {27'b0, mem_wd_i});
        chk({n, ".hi"}, mem_hi, mem_hi_i);
        chk({n, ".lo"}, mem_lo, mem_lo_i);
        chk1({n, ".whilo"}, mem_whilo, mem_whilo_i);
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, r2, rd,
                                input int ack_at, hold, kind, input logic [3:0] sel,
                                input logic [31:0] ld, bw);
        vec_t r;
        r.op = op; r.addr = addr; r.r2 = r2; r.rd = rd; r.ack_at = ack_at;
        r.hold = hold; r.kind = kind; r.sel = sel; r.ld = ld; r.bw = bw;
        return r;
    endfunction

    // reference: size/offset arithmetic on the big-endian byte numbering
    function automatic vec_t model(input vec_t x);
        int sz, off;
        bit sgn;
        logic [31:0] mask, val;
        sgn = 1'b0;
        case (x.op)
            8'hE0: begin sz = 1; sgn = 1'b1; end
            8'hE4, 8'hE8: sz = 1;
            8'hE1: begin sz = 2; sgn = 1'b1; end
            8'hE5, 8'hE9: sz = 2;
            8'hE3, 8'hEB: sz = 4;
            default: sz = 0;
        endcase
        off = int'(x.addr[1:0]);
        x.kind = sz == 0 ? 0 : (off % sz != 0) ? 2 : 1;
        x.sel = '0; x.ld = '0; x.bw = '0;
        if (x.kind != 1) return x;
        x.sel = 4'(((1 << sz) - 1) << (4 - off - sz));
        mask = sz == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
        val = (x.rd >> (8 * (4 - off - sz))) & mask;
        if (sgn && val[8 * sz - 1]) val = val | ~mask;
        x.ld = val;
        x.bw = sz == 1 ? (x.r2 & 32'hFF) * 32'h0101_0101
             : sz == 2 ? (x.r2 & 32'hFFFF) * 32'h0001_0001 : x.r2;
        return x;
    endfunction

    task automatic apply(input logic [7:0] op, input logic [31:0] addr, r2);
        mem_aluop_i = op;
        mem_addr_i  = addr;
        mem_reg2_i  = r2;
        mem_wd_i    = 5'($urandom);
        mem_wreg_i  = !(op inside {8'hE8, 8'hE9, 8'hEB});
        mem_wdata_i = $urandom;
        mem_hi_i    = $urandom;
        mem_lo_i    = $urandom;
        mem_whilo_i = 1'($urandom);
    endtask

    task automatic run(input vec_t x);
        int n;
        bit st, terr;
        @(negedge clk);
        apply(x.op, x.addr, x.r2);
        stall = '0;
        st = x.op inside {8'hE8, 8'hE9, 8'hEB};
        if (x.kind != 1) begin
            bus_if.bus_ack = 1'($urandom);
            #1;
            chk1("pass.req", bus_if.bus_req, 1'b0);
            chk1("pass.stallreq", stallreq, 1'b0);
            chk1("pass.err", mem_err, x.kind == 2);
            chk1("pass.wreg", mem_wreg, x.kind == 2 ? 1'b0 : mem_wreg_i);
            chk("pass.wdata", mem_wdata, mem_wdata_i);
            chk_pass("pass");
            return;
        end
        n = x.ack_at <= T ? x.ack_at + 1 : T + 1;
        terr = x.ack_at > T;
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            stall = 6'b010000;
            bus_if.bus_ack = c == x.ack_at;
            bus_if.bus_rdata = c == x.ack_at ? x.rd : $urandom;
            #1;
            chk1("busy.req", bus_if.bus_req, 1'b1);
            chk1("busy.stallreq", stallreq, 1'b1);
            chk1("busy.we", bus_if.bus_we, st);
            chk("busy.addr", bus_if.bus_addr, {x.addr[31:2], 2'b00});
            chk("busy.sel", {28'b0, bus_if.bus_sel}, {28'b0, x.sel});
            if (st) chk("busy.bwdata", bus_if.bus_wdata, x.bw);
        end
        for (int h = 0; h <= x.hold; h++) begin
            @(negedge clk);
            stall = h < x.hold ? 6'b010000 : 6'b0;
            bus_if.bus_ack = h > 0;
            bus_if.bus_rdata = ~x.rd;
            #1;
            chk1("done.req", bus_if.bus_req, 1'b0);
            chk1("done.stallreq", stallreq, 1'b0);
            chk1("done.err", mem_err, terr);
            chk1("done.wreg", mem_wreg, terr ? 1'b0 : mem_wreg_i);
            if (!st && !terr) chk("done.ldata", mem_wdata, x.ld);
            if (st) chk("done.wdata", mem_wdata, mem_wdata_i);
            chk_pass("done");
        end
    endtask

    initial begin
        tbl[0]  = mk(8'h20, 32'h0,   32'h0,        32'h0,        0,  0, 0, 4'h0, 32'h0,        32'h0);
        tbl[1]  = mk(8'hE0, 32'h103, 32'h0,        32'h123456F0, 0,  0, 1, 4'h1, 32'hFFFFFFF0, 32'h0);
        tbl[2]  = mk(8'hE4, 32'h103, 32'h0,        32'h123456F0, 0,  0, 1, 4'h1, 32'h000000F0, 32'h0);
        tbl[3]  = mk(8'hE1, 32'h102, 32'h0,        32'h123456F0, 3,  0, 1, 4'h3, 32'h000056F0, 32'h0);
        tbl[4]  = mk(8'hEB, 32'h200, 32'hDEADBEEF, 32'h0,        1,  0, 1, 4'hF, 32'h0,        32'hDEADBEEF);
        tbl[5]  = mk(8'hE3, 32'h204, 32'h0,        32'h0,        99, 1, 1, 4'hF, 32'h0,        32'h0);
        tbl[6]  = mk(8'hE0, 32'h100, 32'h0,        32'h80112233, 2,  0, 1, 4'h8, 32'hFFFFFF80, 32'h0);
        tbl[7]  = mk(8'hE1, 32'h100, 32'h0,        32'h80017777, 0,  0, 1, 4'hC, 32'hFFFF8001, 32'h0);
        tbl[8]  = mk(8'hE5, 32'h102, 32'h0,        32'h1234ABCD, 0,  0, 1, 4'h3, 32'h0000ABCD, 32'h0);
        tbl[9]  = mk(8'hE8, 32'h301, 32'h000000A5, 32'h0,        0,  0, 1, 4'h4, 32'h0,        32'hA5A5A5A5);
        tbl[10] = mk(8'hE9, 32'h302, 32'h1234BEEF, 32'h0,        4,  0, 1, 4'h3, 32'h0,        32'hBEEFBEEF);
        tbl[11] = mk(8'hE4, 32'h101, 32'h0,        32'h12AB3456, 0,  2, 1, 4'h4, 32'h000000AB, 32'h0);
        tbl[12] = mk(8'hE3, 32'h300, 32'h0,        32'hCAFEF00D, 1,  0, 1, 4'hF, 32'hCAFEF00D, 32'h0);
        tbl[13] = mk(8'hE3, 32'h201, 32'h0,        32'h0,        0,  0, 2, 4'h0, 32'h0,        32'h0);
        tbl[14] = mk(8'hE1, 32'h103, 32'h0,        32'h0,        0,  0, 2, 4'h0, 32'h0,        32'h0);
        tbl[15] = mk(8'hEB, 32'h202, 32'h0,        32'h0,        0,  0, 2, 4'h0, 32'h0,        32'h0);
        tbl[16] = mk(8'hE9, 32'h101, 32'h0,        32'h0,        0,  0, 2, 4'h0, 32'h0,        32'h0);
        tbl[17] = mk(8'hE5, 32'h100, 32'h0,        32'hFEDC1234, 5,  0, 1, 4'hC, 32'h0,        32'h0);
        tbl[18] = mk(8'h00, 32'h0,   32'h0,        32'h0,        0,  0, 0, 4'h0, 32'h0,        32'h0);

        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = '0;
        apply(8'hE3, 32'h100, 32'h1);
        mem_wd_i = 5'd7;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.wd", {27'b0, mem_wd}, 32'h0);
        chk1("rst.wreg", mem_wreg, 1'b0);
        chk("rst.wdata", mem_wdata, 32'h0);
        chk1("rst.req", bus_if.bus_req, 1'b0);
        chk1("rst.stallreq", stallreq, 1'b0);
        chk1("rst.err", mem_err, 1'b0);
        @(negedge clk);
        mem_aluop_i = 8'h20;
        rst = 1'b1;

        @(negedge clk);
        mem_wd_i = 5'd3; mem_wreg_i = 1'b1; mem_wdata_i = 32'h5;
        #1;
        chk("add.wdata", mem_wdata, 32'h5);
        chk("add.wd", {27'b0, mem_wd}, 32'd3);
        chk1("add.wreg", mem_wreg, 1'b1);
        chk1("add.stallreq", stallreq, 1'b0);
        chk1("add.req", bus_if.bus_req, 1'b0);

        for (int i = 0; i < 19; i++) run(tbl[i]);

        @(negedge clk);
        apply(8'hE3, 32'h400, 32'h0);
        bus_if.bus_ack = 1'b0;
        stall = 6'b010000;
        @(negedge clk);
        #1;
        chk1("wait.req", bus_if.bus_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk1("arst.req", bus_if.bus_req, 1'b0);
        chk1("arst.stallreq", stallreq, 1'b0);
        chk1("arst.err", mem_err, 1'b0);
        chk("arst.wd", {27'b0, mem_wd}, 32'h0);
        mem_aluop_i = 8'h20;
        @(negedge clk);
        rst = 1'b1;
        run(mk(8'hE3, 32'h404, 32'h0, 32'h11223344, 2, 0, 1, 4'hF, 32'h11223344, 32'h0));
        run(mk(8'hE3, 32'h408, 32'h0, 32'h0, 7, 0, 1, 4'hF, 32'h0, 32'h0));

        for (int i = 0; i < 80; i++) begin
            v.op = $urandom_range(0, 9) < 8 ? ops[$urandom_range(0, 7)] : 8'($urandom);
            v.addr = $urandom;
            v.r2 = $urandom;
            v.rd = $urandom;
            v.ack_at = $urandom_range(0, T + 2);
            v.hold = $urandom_range(0, 2);
            run(model(v));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
